spi_master_tx: RTL and testbench
================================

Name: spi_master_tx

Overview:
- Transmit half of the SPI master datapath; the counterpart of the receive shifter.
- Pulls 32-bit words from the TX FIFO through a valid/ready handshake and shifts them out MSB-first on sdo0 (single mode) or sdo3..sdo0 (quad mode).
- Each shift happens on a tx_edge strobe from the clock generator.
- Gates the SPI clock through clk_en_o while the FIFO is empty, and pulses tx_done on the final edge of the programmed bit count.

Parameters:
- None. Widths are fixed by the package: 32-bit word, 16-bit counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- en  in  1  start request from the controller FSM
- tx_edge  in  1  one-cycle shift strobe from the SPI clock generator
- tx_done  out  1  combinational pulse on the last shift edge of the transfer
- sdo0  out  1  serial data / quad lane 0
- sdo1  out  1  quad lane 1
- sdo2  out  1  quad lane 2
- sdo3  out  1  quad lane 3
- en_quad_in  in  1  1 = 4 bits per edge, 0 = 1 bit per edge
- counter_in  in  16  transfer length in bits
- counter_in_upd  in  1  load counter_in into the target register
- data  in  32  TX FIFO read data
- data_valid  in  1  TX FIFO not empty
- data_ready  out  1  pop the TX FIFO (handshake completes when valid && ready)
- clk_en_o  out  1  SPI clock enable

Behaviour:
- Reset (asynchronous, rstn=0): state IDLE, counter=0, counter_trgt=8, shift register=0.
  - All outputs 0: sdo*=0, tx_done=0, data_ready=0, clk_en_o=0.
  - Asserting reset mid-transfer aborts immediately; no FIFO pop occurs.
- Target register:
  - When counter_in_upd=1: counter_trgt <= en_quad_in ? {2'b00, counter_in[15:2]} : counter_in.
  - The new target takes effect from the next cycle.
  - counter_trgt=0 is unsupported.
- tx_done = (counter == counter_trgt-1) && tx_edge, using 16-bit wrap arithmetic.
- reg_done = quad ? (counter[2:0]==7) : (counter[4:0]==31). It marks the last edge of the current word.
- Outputs from the shift register sr:
  - Single mode: sdo0 = sr[31]; sdo1..sdo3 = 0.
  - Quad mode: {sdo3, sdo2, sdo1, sdo0} = sr[31:28].
- IDLE state:
  - clk_en_o=0 and data_ready=en.
  - If en && data_valid: load sr <= data, counter <= 0, go to TRANSMIT.
  - Otherwise stay in IDLE; the clock stays gated until data arrives.
  - tx_edge is ignored in IDLE.
- TRANSMIT state, clk_en_o=1. On tx_edge:
  - counter++.
  - sr shifts left by 1 (single) or 4 (quad), zero-filled.
  - If tx_done: counter <= 0, go to IDLE. tx_done has priority over reg_done; no pop occurs on the final word.
  - Else if reg_done: data_ready=1.
    - If data_valid: sr <= data. The shift is replaced by the load, with no bubble.
    - Otherwise: clk_en_o=0 in that same cycle, go to WAIT_FIFO.
- WAIT_FIFO state:
  - clk_en_o=0, data_ready=1.
  - When data_valid arrives: sr <= data, go to TRANSMIT.
  - counter is held.
- en deasserting mid-transfer is ignored until tx_done.
- data_ready is asserted only in the cycles listed above. It is never asserted while data_valid=0 in a way that pops stale data: a pop requires valid && ready.
- Latency:
  - First bit is on sdo the cycle after the IDLE load.
  - Each new bit/nibble is visible the cycle after its tx_edge.

Optional Feature:
- Macro: SPI_MASTER_TX_LSB_FIRST_EN.
- Defined:
  - sr shifts right.
  - Single mode: sdo0 = sr[0].
  - Quad mode: {sdo3, sdo2, sdo1, sdo0} = sr[3:0].
- Undefined: MSB-first, as specified above.
- Counters, handshake and states are identical in both builds.

Decomposition:
- Package spi_master_pkg holds:
  - typedef enum logic [1:0] {TX_IDLE, TX_TRANSMIT, TX_WAIT_FIFO} spi_tx_state_e;
  - localparams SPI_WORD_W=32, SPI_CNT_W=16, SPI_CNT_TRGT_RST=16'h8.
- No sub-module: the FSM and shifter are single-flop-stage logic and stay in one module.

Test Plan:
- Single, counter_in=8, data=0xA5000000, en=1, one tx_edge every 4 cycles -> sdo0 sequence 1,0,1,0,0,1,0,1; tx_done pulses on the 8th edge; return to IDLE; exactly one pop.
- Quad, counter_in=32, data=0x12345678 -> nibbles 1..8 on sdo3..sdo0; tx_done on the 8th edge.
- Single, counter_in=64, words 0xFFFF0000 then 0x0000FFFF back-to-back -> second word loaded on edge 32 with no gap; two pops; tx_done on edge 64.
- Same as the previous case but the FIFO is empty at edge 32 -> clk_en_o drops the same cycle; WAIT_FIFO with data_ready=1 is held 10 cycles; on data_valid the transfer resumes with bit 33 = 0 and counter=32 preserved.
- rstn pulsed low during edge 5 of a 32-bit transfer -> all outputs 0 immediately; counter_trgt=8; next transfer sends 8 bits.
- counter_in_upd with counter_in=16 while quad -> target 4; tx_done on the 4th edge.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared types and widths for the SPI master datapath.
// The shift helper honours SPI_MASTER_TX_LSB_FIRST_EN so the bit order lives in one place.
package spi_master_pkg;

    localparam int SPI_WORD_W = 32;
    localparam int SPI_CNT_W  = 16;
    localparam logic [SPI_CNT_W-1:0] SPI_CNT_TRGT_RST = 16'h8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_TRANSMIT,
        TX_WAIT_FIFO
    } spi_tx_state_e;

    // One shift step: 4 bits per edge in quad mode, 1 bit otherwise, zero-filled.
    function automatic logic [SPI_WORD_W-1:0] spi_shift(input logic [SPI_WORD_W-1:0] sr,
                                                        input logic quad);
`ifdef SPI_MASTER_TX_LSB_FIRST_EN
        return quad ? (sr >> 4) : (sr >> 1);
`else
        return quad ? (sr << 4) : (sr << 1);
`endif
    endfunction

endpackage

// File: rtl/spi_master_tx.sv
// SPI master transmit shifter: pops 32-bit words and shifts them out on sdo0 or sdo3..sdo0 (SPI_MASTER_TX_LSB_FIRST_EN flips bit order).
// Latency: first bit on sdo the cycle after the IDLE load; each later bit/nibble the cycle after its tx_edge.
// Backpressure: an empty FIFO at a word boundary parks in WAIT_FIFO with clk_en_o low until data_valid returns.
module spi_master_tx
    import spi_master_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic        tx_edge,
    output logic        tx_done,
    output logic        sdo0,
    output logic        sdo1,
    output logic        sdo2,
    output logic        sdo3,
    input  logic        en_quad_in,
    input  logic [15:0] counter_in,
    input  logic        counter_in_upd,
    input  logic [31:0] data,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        clk_en_o
);

    spi_tx_state_e         state;
    logic [SPI_CNT_W-1:0]  counter;
    logic [SPI_CNT_W-1:0]  counter_trgt;
    logic [SPI_CNT_W-1:0]  cnt_last;
    logic [SPI_WORD_W-1:0] sr;
    logic [SPI_WORD_W-1:0] sr_shifted;
    logic                  reg_done;

    assign cnt_last   = counter_trgt - 16'd1;
    assign reg_done   = en_quad_in ? (counter[2:0] == 3'd7) : (counter[4:0] == 5'd31);
    assign sr_shifted = spi_shift(sr, en_quad_in);

`ifdef SPI_MASTER_TX_LSB_FIRST_EN
    assign sdo0 = sr[0];
    assign sdo1 = en_quad_in & sr[1];
    assign sdo2 = en_quad_in & sr[2];
    assign sdo3 = en_quad_in & sr[3];
`else
    assign sdo0 = en_quad_in ? sr[28] : sr[31];
    assign sdo1 = en_quad_in & sr[29];
    assign sdo2 = en_quad_in & sr[30];
    assign sdo3 = en_quad_in & sr[31];
`endif

    // Handshake and clock gating are combinational so a starved boundary gates the clock in the same cycle.
    always_comb begin
        tx_done    = 1'b0;
        data_ready = 1'b0;
        clk_en_o   = 1'b0;
        case (state)
            TX_IDLE: begin
                data_ready = en;
            end
            TX_TRANSMIT: begin
                clk_en_o = 1'b1;
                tx_done  = tx_edge && (counter == cnt_last);
                if (tx_edge && !tx_done && reg_done) begin
                    data_ready = 1'b1;
                    if (!data_valid) begin
                        clk_en_o = 1'b0;
                    end
                end
            end
            TX_WAIT_FIFO: begin
                data_ready = 1'b1;
            end
            default: begin
                data_ready = 1'b0;
            end
        endcase
    end

    // Quad mode counts nibbles, so the target is the bit count divided by four.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            counter_trgt <= SPI_CNT_TRGT_RST;
        end else if (counter_in_upd) begin
            counter_trgt <= en_quad_in ? {2'b00, counter_in[15:2]} : counter_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= TX_IDLE;
            counter <= '0;
            sr      <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (en && data_valid) begin
                        sr      <= data;
                        counter <= '0;
                        state   <= TX_TRANSMIT;
                    end
                end
                TX_TRANSMIT: begin
                    if (tx_edge) begin
                        if (tx_done) begin
                            sr      <= sr_shifted;
                            counter <= '0;
                            state   <= TX_IDLE;
                        end else begin
                            counter <= counter + 16'd1;
                            if (reg_done && data_valid) begin
                                sr <= data;
                            end else begin
                                sr <= sr_shifted;
                                if (reg_done) begin
                                    state <= TX_WAIT_FIFO;
                                end
                            end
                        end
                    end
                end
                TX_WAIT_FIFO: begin
                    if (data_valid) begin
                        sr    <= data;
                        state <= TX_TRANSMIT;
                    end
                end
                default: begin
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed plus randomized bench for spi_master_tx against a word-list symbol model.
module tb_spi_master_tx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        tx_edge = 1'b0;
    logic        en_quad_in = 1'b0;
    logic [15:0] counter_in = 16'd0;
    logic        counter_in_upd = 1'b0;
    logic [31:0] data = 32'd0;
    logic        data_valid = 1'b0;
    logic        tx_done, sdo0, sdo1, sdo2, sdo3, data_ready, clk_en_o;

    spi_master_tx dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .tx_edge        (tx_edge),
        .tx_done        (tx_done),
        .sdo0           (sdo0),
        .sdo1           (sdo1),
        .sdo2           (sdo2),
        .sdo3           (sdo3),
        .en_quad_in     (en_quad_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .data           (data),
        .data_valid     (data_valid),
        .data_ready     (data_ready),
        .clk_en_o       (clk_en_o)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          pops = 0;
    int          model_trgt = 8;
    bit          hold = 1'b0;
    logic [31:0] fifo[$];
    logic [31:0] words[$];
    logic        o_done, o_rdy, o_clken;
    logic [3:0]  o_sdo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k-th symbol of the serial stream built from the word list.
    function automatic logic [3:0] sym(input bit quad, input int k);
        int per;
        int j;
        logic [31:0] w;
        per = quad ? 8 : 32;
        w = words[k / per];
        j = k % per;
`ifdef SPI_MASTER_TX_LSB_FIRST_EN
        return quad ? 4'(w >> (4 * j)) : {3'b000, w[j]};
`else
        return quad ? 4'(w >> (28 - 4 * j)) : {3'b000, w[31 - j]};
`endif
    endfunction

    // One clock: drive at negedge, observe 1 ns later, model the FIFO pop at posedge.
    task automatic cyc(input logic edge_i);
        @(negedge clk);
        tx_edge = edge_i;
        data_valid = (fifo.size() > 0) && !hold;
        data = data_valid ? fifo[0] : 32'hDEAD_BEEF;
        #1;
        o_done = tx_done;
        o_rdy = data_ready;
        o_clken = clk_en_o;
        o_sdo = {sdo3, sdo2, sdo1, sdo0};
        @(posedge clk);
        if (data_valid && o_rdy) begin
            void'(fifo.pop_front());
            pops++;
        end
        #1;
        tx_edge = 1'b0;
    endtask

    task automatic transfer(input bit quad, input bit upd, input logic [15:0] cnt, input int gap,
                            input int stall_at, input int stall_cyc, input int abort_at);
        int nedges, per, nwords, e;
        bit boundary;
        en_quad_in = quad;
        if (upd) begin
            counter_in = cnt;
            counter_in_upd = 1'b1;
            cyc(1'b0);
            counter_in_upd = 1'b0;
            model_trgt = quad ? int'(cnt >> 2) : int'(cnt);
        end
        per = quad ? 8 : 32;
        nedges = model_trgt;
        nwords = (nedges + per - 1) / per;
        pops = 0;
        fifo = {};
        for (int i = 0; i < nwords; i++) fifo.push_back(words[i]);
        fifo.push_back(32'h5A5A_5A5A);
        en = 1'b0;
        cyc(1'b0);
        chk("idle_rdy", 32'(o_rdy), 32'd0);
        chk("idle_clken", 32'(o_clken), 32'd0);
        en = 1'b1;
        cyc(1'b1);
        chk("load_rdy", 32'(o_rdy), 32'd1);
        chk("load_clken", 32'(o_clken), 32'd0);
        chk("load_done", 32'(o_done), 32'd0);
        en = 1'b0;
        e = 0;
        while (e < nedges) begin
            for (int g = 0; g < gap; g++) begin
                cyc(1'b0);
                chk("sdo_hold", 32'(o_sdo), 32'(sym(quad, e)));
                chk("run_clken", 32'(o_clken), 32'd1);
            end
            if (e + 1 == abort_at) begin
                @(negedge clk);
                tx_edge = 1'b1;
                #2 rstn = 1'b0;
                #1;
                chk("abort_sdo", 32'({sdo3, sdo2, sdo1, sdo0}), 32'd0);
                chk("abort_done", 32'(tx_done), 32'd0);
                chk("abort_rdy", 32'(data_ready), 32'd0);
                chk("abort_clken", 32'(clk_en_o), 32'd0);
                #1 rstn = 1'b1;
                tx_edge = 1'b0;
                @(posedge clk);
                #1;
                model_trgt = 8;
                chk("abort_pops", 32'(pops), 32'd1);
                fifo = {};
                return;
            end
            if (e + 1 == stall_at) hold = 1'b1;
            cyc(1'b1);
            e++;
            boundary = (e % per == 0) && (e < nedges);
            chk("edge_sdo", 32'(o_sdo), 32'(sym(quad, e - 1)));
            chk("edge_done", 32'(o_done), 32'(e == nedges));
            chk("edge_rdy", 32'(o_rdy), 32'(boundary));
            chk("edge_clken", 32'(o_clken), 32'(!(boundary && hold)));
            if (hold) begin
                for (int w = 0; w < stall_cyc; w++) begin
                    cyc(1'b0);
                    chk("wait_rdy", 32'(o_rdy), 32'd1);
                    chk("wait_clken", 32'(o_clken), 32'd0);
                end
                hold = 1'b0;
                cyc(1'b0);
                chk("resume_rdy", 32'(o_rdy), 32'd1);
            end
        end
        cyc(1'b0);
        chk("end_clken", 32'(o_clken), 32'd0);
        chk("end_rdy", 32'(o_rdy), 32'd0);
        chk("pops", 32'(pops), 32'(nwords));
        fifo = {};
    endtask

    initial begin
        bit q;
        int cnt, st;
        #2;
        chk("rst_sdo", 32'({sdo3, sdo2, sdo1, sdo0}), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_rdy", 32'(data_ready), 32'd0);
        chk("rst_clken", 32'(clk_en_o), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        words = {32'hA500_0000};
        transfer(1'b0, 1'b1, 16'd8, 3, 0, 0, 0);
        words = {32'h1234_5678};
        transfer(1'b1, 1'b1, 16'd32, 3, 0, 0, 0);
        words = {32'hFFFF_0000, 32'h0000_FFFF};
        transfer(1'b0, 1'b1, 16'd64, 3, 0, 0, 0);
        transfer(1'b0, 1'b1, 16'd64, 3, 32, 10, 0);
        words = {$urandom(), $urandom()};
        transfer(1'b0, 1'b1, 16'd32, 3, 0, 0, 5);
        words = {$urandom()};
        transfer(1'b0, 1'b0, 16'd0, 3, 0, 0, 0);
        words = {$urandom()};
        transfer(1'b1, 1'b1, 16'd16, 3, 0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            words = {$urandom(), $urandom(), $urandom(), $urandom()};
            q = 1'($urandom_range(0, 1));
            cnt = q ? $urandom_range(4, 96) : $urandom_range(1, 80);
            st = 0;
            if (((q ? cnt / 4 : cnt) > (q ? 8 : 32)) && ($urandom_range(0, 1) == 1)) st = q ? 8 : 32;
            transfer(q, 1'b1, 16'(cnt), $urandom_range(0, 3), st, $urandom_range(1, 5), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
